// File: rtl/seven_seg_mux_ctrl.sv
// seven_seg_mux_ctrl: time-multiplexes one hex decoder across two seven-segment digits with blanking gaps
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous active-low reset
//   s0, s1     in   [3:0] hex nibbles for digit 0 / digit 1
//   blank_req  in   forces both enables low without disturbing sequencing
//   s          out  [3:0] nibble to the shared decoder
//   en0, en1   out  digit enables, active-high, never both high
//   digit      out  index of the digit owning s
module seven_seg_mux_ctrl #(
   parameter int REFRESH_CYCLES = 24000,
   parameter int BLANK_CYCLES   = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] s0,
   input  logic [3:0] s1,
   input  logic       blank_req,
   output logic [3:0] s,
   output logic       en0,
   output logic       en1,
   output logic       digit
);
   localparam int MAXC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC);
   localparam logic [CW-1:0] LAST_R = CW'(REFRESH_CYCLES - 1);
   localparam logic [CW-1:0] LAST_B = CW'(BLANK_CYCLES - 1);
   // Encoding chosen so the sequence is a plain increment and bit 1 is the owning digit
   localparam logic [1:0] DISP0  = 2'd0;
   localparam logic [1:0] BLANK0 = 2'd1;
   localparam logic [1:0] DISP1  = 2'd2;
   localparam logic [1:0] BLANK1 = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_s;
   logic          r_en0;
   logic          r_en1;
   logic          w_last;
   logic [1:0]    w_next;

   always_comb begin
      w_last = r_cnt == (r_state[0] ? LAST_B : LAST_R);
      w_next = w_last ? r_state + 2'd1 : r_state;
   end

   // r_s only loads on DISP entry, so it doubles as the latched nibble and holds through BLANK
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= BLANK1;
         r_cnt   <= '0;
         r_s     <= 4'd0;
         r_en0   <= 1'b0;
         r_en1   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
         r_s     <= (w_last && w_next == DISP0) ? s0 : (w_last && w_next == DISP1) ? s1 : r_s;
         r_en0   <= (w_next == DISP0) & ~blank_req;
         r_en1   <= (w_next == DISP1) & ~blank_req;
      end
   end

   assign s     = r_s;
   assign en0   = r_en0;
   assign en1   = r_en1;
   assign digit = r_state[1];
endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// tb_seven_seg_mux_ctrl: directed scenario bench for seven_seg_mux_ctrl with REFRESH_CYCLES=4, BLANK_CYCLES=2
module tb_seven_seg_mux_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] s0 = 4'h0;
   logic [3:0] s1 = 4'h0;
   logic       blank_req = 1'b0;
   logic [3:0] s;
   logic       en0;
   logic       en1;
   logic       digit;
   int         n_cmp = 0;
   int         n_err = 0;

   seven_seg_mux_ctrl #(.REFRESH_CYCLES(4), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .s0(s0), .s1(s1), .blank_req(blank_req),
      .s(s), .en0(en0), .en1(en1), .digit(digit)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      n_cmp++;
      if (en0 === 1'b1 && en1 === 1'b1) begin
         n_err++;
         $display("FAIL mutex t=%0t: en0=%b en1=%b required not both 1", $time, en0, en1);
      end
   end

   task automatic test_reset();
      s0 = 4'hA;
      s1 = 4'h3;
      blank_req = 1'b0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({s, en0, en1, digit} !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: s=%h en0=%b en1=%b digit=%b required s=0 en0=0 en1=0 digit=1", s, en0, en1, digit);
      end
   endtask

   task automatic test_first_frame(input logic [3:0] a, input logic [3:0] b);
      logic       e0, e1, ed;
      logic [3:0] es;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         e0 = (i >= 2 && i <= 5);
         e1 = (i >= 8);
         ed = (i < 2 || i >= 8);
         es = (i < 2) ? 4'h0 : (i < 8) ? a : b;
         n_cmp++;
         if ({en0, en1, digit, s} !== {e0, e1, ed, es}) begin
            n_err++;
            $display("FAIL first_frame[%0d]: en0=%b en1=%b digit=%b s=%h required en0=%b en1=%b digit=%b s=%h",
                     i, en0, en1, digit, s, e0, e1, ed, es);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_periodicity();
      logic p0 = 1'b0, p1 = 1'b0;
      int   last_rise = -1, rises = 0, run0 = 0, run1 = 0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (en0 && !p0) begin
            if (last_rise >= 0) begin
               n_cmp++;
               if (i - last_rise != 12) begin
                  n_err++;
                  $display("FAIL period: en0 rise spacing=%0d required 12", i - last_rise);
               end
            end
            last_rise = i;
            rises++;
         end
         if (en0) run0++;
         else if (p0) begin
            n_cmp++;
            if (run0 != 4) begin n_err++; $display("FAIL en0_width: high %0d cycles required 4", run0); end
            run0 = 0;
         end
         if (en1) run1++;
         else if (p1) begin
            n_cmp++;
            if (run1 != 4) begin n_err++; $display("FAIL en1_width: high %0d cycles required 4", run1); end
            run1 = 0;
         end
         p0 = en0;
         p1 = en1;
         @(negedge clk);
      end
      n_cmp++;
      if (rises != 5) begin n_err++; $display("FAIL en0_rises: saw %0d required 5", rises); end
   endtask

   task automatic test_latching();
      logic [3:0] es;
      s0 = 4'h1;
      for (int w = 0; w < 24; w++) begin
         #1;
         es = (w < 2) ? 4'h3 : (w < 8) ? 4'h1 : (w < 14) ? 4'h3 : (w < 20) ? 4'hF : 4'h3;
         n_cmp++;
         if (s !== es) begin
            n_err++;
            $display("FAIL latch[%0d]: s=%h required %h", w, s, es);
         end
         if (w == 3) s0 = 4'hF;
         @(negedge clk);
      end
   endtask

   task automatic test_blank_req();
      int         p;
      logic       e0, e1, ed;
      logic [3:0] es;
      for (int w = 0; w < 24; w++) begin
         #1;
         p  = w % 12;
         e0 = (p >= 2 && p <= 5) && !(w == 15 || w == 16);
         e1 = (p >= 8) && !(w >= 9 && w <= 11);
         ed = (p < 2 || p >= 8);
         es = (p < 2 || p >= 8) ? 4'h3 : 4'hF;
         n_cmp++;
         if ({en0, en1, digit, s} !== {e0, e1, ed, es}) begin
            n_err++;
            $display("FAIL blank_req[%0d]: en0=%b en1=%b digit=%b s=%h required en0=%b en1=%b digit=%b s=%h",
                     w, en0, en1, digit, s, e0, e1, ed, es);
         end
         if (w == 8 || w == 14) blank_req = 1'b1;
         if (w == 11 || w == 16) blank_req = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      repeat (3) begin #1; @(negedge clk); end
      #1;
      n_cmp++;
      if ({en0, s} !== {1'b1, 4'hF}) begin
         n_err++;
         $display("FAIL pre_async: en0=%b s=%h required en0=1 s=f", en0, s);
      end
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if ({en0, en1, s, digit} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
         n_err++;
         $display("FAIL async_reset: en0=%b en1=%b s=%h digit=%b required en0=0 en1=0 s=0 digit=1", en0, en1, s, digit);
      end
      test_first_frame(4'hF, 4'h3);
   endtask

   task automatic test_all_nibbles();
      logic [3:0] prev_b = 4'h3;
      logic [3:0] a, b, es;
      for (int k = 0; k < 16; k++) begin
         a  = 4'(k);
         b  = 4'(15 - k);
         s0 = a;
         s1 = b;
         for (int p = 0; p < 12; p++) begin
            #1;
            es = (p < 2) ? prev_b : (p < 8) ? a : b;
            n_cmp++;
            if (s !== es) begin
               n_err++;
               $display("FAIL nibble[%0d][%0d]: s=%h required %h", k, p, s, es);
            end
            @(negedge clk);
         end
         prev_b = b;
      end
   endtask

   initial begin
      test_reset();
      test_first_frame(4'hA, 4'h3);
      test_periodicity();
      test_latching();
      test_blank_req();
      test_async_reset();
      test_all_nibbles();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/seven_seg_mux_ctrl.md
# seven_seg_mux_ctrl

Time-multiplexing scheduler that shares one combinational `seven_seg_disp` hex decoder between two physical seven-segment digits. It drives the decoder's 4-bit input `s` and the two digit-enable lines. It alternates digits at a fixed refresh rate and inserts an all-off blanking gap at each switch to suppress ghosting. It sits between the board's two nibble sources and the shared decoder/segment pins.

## Interface
- `REFRESH_CYCLES`, default 24000: clock cycles each digit is displayed (0.5 ms at 48 MHz); must be >= 2.
- `BLANK_CYCLES`, default 1000: clock cycles both digits are off between switches; must be >= 1.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s0`  in  4  hex nibble for digit 0.
- `s1`  in  4  hex nibble for digit 1.
- `blank_req`  in  1  when 1, both enables are forced to 0; sequencing continues.
- `s`  out  4  nibble to the shared `seven_seg_disp` input.
- `en0`  out  1  digit 0 enable, active-high.
- `en1`  out  1  digit 1 enable, active-high.
- `digit`  out  1  index of the digit that owns `s` (0 or 1).

## Operation
- The FSM has four states, each with a cycle counter `cnt`:
  - DISP0 -> BLANK0 -> DISP1 -> BLANK1 -> DISP0 ...
  - DISP states last exactly REFRESH_CYCLES cycles.
  - BLANK states last exactly BLANK_CYCLES cycles.
- `cnt` width is `$clog2(max(REFRESH_CYCLES, BLANK_CYCLES))`.
  - `cnt` resets to 0 on every state change.
  - The state advances on the cycle where `cnt == duration-1`.
- Input latching:
  - `s0` is sampled into an internal register on the edge that enters DISP0.
  - `s1` is sampled on the edge that enters DISP1.
  - Changes to `s0`/`s1` during DISP are not visible until that digit's next DISP entry.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - DISP0: `en0 = ~blank_req`, `en1 = 0`, `s` = latched `s0`, `digit = 0`.
  - DISP1: `en1 = ~blank_req`, `en0 = 0`, `s` = latched `s1`, `digit = 1`.
  - BLANK0/BLANK1: `en0 = en1 = 0`. `s` and `digit` hold the last DISP values, so the decoder output does not toggle while both digits are off.
- `en0` and `en1` are never 1 in the same cycle, under any input combination.
- `blank_req` is sampled every cycle. It affects only the enables, never the state, counter or `s`.
- Reset (`reset == 0`, asynchronous):
  - state = BLANK1, `cnt` = 0, latched nibbles = 0.
  - `s = 0`, `en0 = 0`, `en1 = 0`, `digit = 1`.
  - Asserting reset mid-DISP drops the enables immediately, without waiting for a clock edge.
- After reset deassertion, the first BLANK1 lasts the full BLANK_CYCLES, then DISP0 is entered.

## Timing
- Full frame is `2*(REFRESH_CYCLES + BLANK_CYCLES)` cycles.
- Latency from an input nibble change to `s`:
  - minimum 1 cycle, if the change lands exactly before a DISP entry edge;
  - maximum one full frame.
- `blank_req` to enables is 1 cycle (registered).
- Reset release takes effect on the first rising edge where `reset == 1`.
- Reset release is assumed synchronous to `clk` at board level; no internal synchronizer.
- Digit-switch gap: the falling edge of `en0` and the rising edge of `en1` are separated by exactly BLANK_CYCLES cycles, and vice versa.

## Test plan
Parameters for all scenarios: REFRESH_CYCLES=4, BLANK_CYCLES=2. Checks are made at negedge, error counts are reported, and every cycle asserts `!(en0 && en1)`.

- **Reset state and first frame:** hold `reset = 0` with `s0 = 4'hA`, `s1 = 4'h3`, `blank_req = 0`.
  - During reset: `s = 0`, `en0 = en1 = 0`, `digit = 1`.
  - After release: 2 cycles with both enables 0.
  - Then 4 cycles with `en0 = 1`, `s = 4'hA`; then 2 off; then 4 cycles with `en1 = 1`, `s = 4'h3`.
- **Frame periodicity:** run 5 frames.
  - The `en0` rising-edge spacing is exactly 12 cycles.
  - `en0` and `en1` are each high for exactly 4 consecutive cycles per frame.
- **Input latching:** change `s0` from `4'h1` to `4'hF` in the 2nd cycle of DISP0.
  - `s` stays `4'h1` for the remainder of DISP0.
  - `s = 4'hF` from the next DISP0 entry.
- **blank_req:** assert `blank_req` for 3 cycles starting mid-DISP1.
  - `en1` drops 1 cycle later and returns 1 cycle after deassertion.
  - `s`, `digit` and the next DISP0 entry time are unchanged.
- **Asynchronous reset mid-display:** pull `reset` low between clock edges during DISP0.
  - `en0 = 0` and `s = 0` without a clock edge.
  - After release, the sequence restarts from BLANK1 exactly as in the first scenario.
- **All 16 nibbles:** sweep `s0`, `s1` over 0..F, one value per frame.
  - `s` matches the latched value in every DISP cycle.
  - `s` holds that value through the following BLANK.
